// File: rtl/fpu_mult_arbiter_pkg.sv
// Shared types and defaults for the MPU's shared FPU multiplier path.
// Provides operand type, requester id/tag types and a wrap helper.
package fpu_mult_arbiter_pkg;

   typedef logic [31:0] float_t;

   localparam int FPU_MULT_LATENCY = 3;
   localparam int NUM_MPU_REQ      = 4;

   typedef logic [$clog2(NUM_MPU_REQ)-1:0] req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
   } mult_tag_t;

   // Folds v (assumed < 2*n) back into 0..n-1.
   function automatic int rr_wrap(input int v, input int n);
      return (v >= n) ? v - n : v;
   endfunction

endpackage

// File: rtl/fpu_mult_arbiter_rr_arbiter.sv
// Round-robin arbiter: first eligible index at or after ptr wins.
// Ports: eligible (request mask), ptr (search start) -> grant (one-hot),
//        grant_id (binary index of the winner), any (a winner exists).
module rr_arbiter
   import fpu_mult_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] eligible,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_id,
   output logic               any
);

   logic [ID_W-1:0] idx;

   always_comb begin
      grant    = '0;
      grant_id = '0;
      any      = 1'b0;
      idx      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = ID_W'(rr_wrap(int'(ptr) + k, NUM_REQ));
         if (!any && eligible[idx]) begin
            any       = 1'b1;
            grant[idx] = 1'b1;
            grant_id  = idx;
         end
      end
   end

endmodule

// File: rtl/fpu_mult_arbiter.sv
// Shares one fixed-latency pipelined FPU multiplier among NUM_REQ requesters,
// with round-robin issue, a tag pipeline for result ownership and held responses.
// Ports: clk, rst (sync, active-high);
//        req_valid/req_ready/req_a/req_b   - per-requester issue handshake;
//        resp_valid/resp_ready/resp_data   - per-requester held result;
//        mult_start/mult_a/mult_b          - issue to the shared multiplier;
//        mult_done/mult_result             - product from the multiplier;
//        proto_err                         - sticky tag/done disagreement.
module fpu_mult_arbiter
   import fpu_mult_arbiter_pkg::*;
#(
   parameter int NUM_REQ      = NUM_MPU_REQ,
   parameter int DATA_WIDTH   = $bits(float_t),
   parameter int MULT_LATENCY = FPU_MULT_LATENCY
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_REQ-1:0]                 req_valid,
   output logic [NUM_REQ-1:0]                 req_ready,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_a,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_b,
   output logic [NUM_REQ-1:0]                 resp_valid,
   input  logic [NUM_REQ-1:0]                 resp_ready,
   output logic [NUM_REQ-1:0][DATA_WIDTH-1:0] resp_data,
   output logic                               mult_start,
   output logic [DATA_WIDTH-1:0]              mult_a,
   output logic [DATA_WIDTH-1:0]              mult_b,
   input  logic                               mult_done,
   input  logic [DATA_WIDTH-1:0]              mult_result,
   output logic                               proto_err
);

   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] busy;
   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] grant;
   logic [NUM_REQ-1:0] resp_fire;
   logic [ID_W-1:0]    ptr;
   logic [ID_W-1:0]    grant_id;
   logic               any;
   logic               accept;

   // Tag slot k holds the op issued k+1 cycles ago; the last slot lines
   // up with the cycle its mult_done is due.
   logic [MULT_LATENCY:0]           tag_v;
   logic [MULT_LATENCY:0][ID_W-1:0] tag_id;
   logic                            exit_v;
   logic [ID_W-1:0]                 exit_id;
   logic                            done_hit;

   assign eligible = req_valid & ~busy;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .eligible (eligible),
      .ptr      (ptr),
      .grant    (grant),
      .grant_id (grant_id),
      .any      (any)
   );

   // Grants are masked while reset is held so every output reads 0.
   assign req_ready = rst ? '0 : grant;
   assign accept    = any & ~rst;

   assign exit_v    = tag_v[MULT_LATENCY];
   assign exit_id   = tag_id[MULT_LATENCY];
   assign done_hit  = mult_done & exit_v;
   assign resp_fire = resp_valid & resp_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         busy       <= '0;
         ptr        <= '0;
         tag_v      <= '0;
         tag_id     <= '0;
         mult_start <= 1'b0;
         mult_a     <= '0;
         mult_b     <= '0;
         resp_valid <= '0;
         resp_data  <= '0;
         proto_err  <= 1'b0;
      end else begin
         mult_start <= accept;
         if (accept) begin
            mult_a <= req_a[grant_id];
            mult_b <= req_b[grant_id];
            ptr    <= ID_W'(rr_wrap(int'(grant_id) + 1, NUM_REQ));
         end

         tag_v  <= {tag_v[MULT_LATENCY-1:0], accept};
         tag_id <= {tag_id[MULT_LATENCY-1:0], grant_id};

         // A stray done is dropped; a missing done leaves busy set.
         if (mult_done != exit_v)
            proto_err <= 1'b1;

         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i])
               busy[i] <= 1'b1;
            else if (resp_fire[i])
               busy[i] <= 1'b0;

            // One outstanding op per requester keeps this slot free.
            if (done_hit && exit_id == ID_W'(i)) begin
               resp_valid[i] <= 1'b1;
               resp_data[i]  <= mult_result;
            end else if (resp_fire[i]) begin
               resp_valid[i] <= 1'b0;
            end
         end
      end
   end

endmodule
